// File: rtl/shiftreg_univ_if.sv
// Bus bundle for shiftreg_univ: control, serial/parallel data and status.
// With SHIFTREG_ROTATE_EN defined, an extra 'rot' control bit is carried.
// master = the side that drives control/data, slave = the shift register.
interface shiftreg_univ_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) ();

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic                     en;
  logic [1:0]               mode;
  logic [WIDTH-1:0]         sin_lo;
  logic [WIDTH-1:0]         sin_hi;
  logic [WIDTH*DEPTH-1:0]   pdin;
  logic [WIDTH*DEPTH-1:0]   pdout;
  logic [WIDTH-1:0]         sout_hi;
  logic [WIDTH-1:0]         sout_lo;
  logic [FILL_W-1:0]        fill;
  logic                     full;

`ifdef SHIFTREG_ROTATE_EN
  logic                     rot;

  modport master (
    output en, mode, sin_lo, sin_hi, pdin, rot,
    input  pdout, sout_hi, sout_lo, fill, full
  );

  modport slave (
    input  en, mode, sin_lo, sin_hi, pdin, rot,
    output pdout, sout_hi, sout_lo, fill, full
  );
`else
  modport master (
    output en, mode, sin_lo, sin_hi, pdin,
    input  pdout, sout_hi, sout_lo, fill, full
  );

  modport slave (
    input  en, mode, sin_lo, sin_hi, pdin,
    output pdout, sout_hi, sout_lo, fill, full
  );
`endif

endinterface

// File: rtl/shiftreg_univ.sv
// Universal shift register: hold, shift up, shift down, parallel load.
// DEPTH stages of WIDTH bits; stage k lives at pdout[k*WIDTH +: WIDTH].
// 'fill' counts stages holding written data (saturates at DEPTH); 'full'
// follows fill == DEPTH and, since fill never decreases, stays up until reset.
// Optional feature: define SHIFTREG_ROTATE_EN to add bus.rot, which turns
// both shift modes into rotations that leave fill untouched.
// All outputs are taken straight from registered state.
module shiftreg_univ #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  shiftreg_univ_if.slave bus
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic                        rot_sel;

`ifdef SHIFTREG_ROTATE_EN
  assign rot_sel = bus.rot;
`else
  assign rot_sel = 1'b0;
`endif

  // Next-state for stages and fill; en=0 or hold mode leaves both unchanged.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_UP: begin
          for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
          stage_d[0] = rot_sel ? stage_q[DEPTH-1] : bus.sin_lo;
          if (!rot_sel && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        MODE_DOWN: begin
          for (int k = 0; k < DEPTH - 1; k++) begin
            stage_d[k] = stage_q[k+1];
          end
          stage_d[DEPTH-1] = rot_sel ? stage_q[0] : bus.sin_hi;
          if (!rot_sel && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        MODE_LOAD: begin
          stage_d = bus.pdin;
          fill_d  = FILL_MAX;
        end
        default: begin
          stage_d = stage_q;
          fill_d  = fill_q;
        end
      endcase
    end
  end

  // State registers; active-low synchronous reset overrides en and mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      fill_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.pdout   = stage_q;
  assign bus.sout_hi = stage_q[DEPTH-1];
  assign bus.sout_lo = stage_q[0];
  assign bus.fill    = fill_q;
  assign bus.full    = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_shiftreg_univ.sv
// Directed testbench for shiftreg_univ with WIDTH=4, DEPTH=4.
// Rotation steps are compiled in only when SHIFTREG_ROTATE_EN is defined.
module tb_shiftreg_univ;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  shiftreg_univ_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shiftreg_univ #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs, let the rising edge happen, settle 1 unit after it.
  task automatic apply_stimulus(input logic rst_v, input logic en_v,
                                input logic [1:0] mode_v,
                                input logic [3:0] sin_lo_v,
                                input logic [3:0] sin_hi_v,
                                input logic [15:0] pdin_v);
    rst        = rst_v;
    bus.en     = en_v;
    bus.mode   = mode_v;
    bus.sin_lo = sin_lo_v;
    bus.sin_hi = sin_hi_v;
    bus.pdin   = pdin_v;
    @(posedge clk);
    #1;
  endtask

  // Single comparison with failure counting.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check every output against an expected stage image, fill and full.
  task automatic check_state(input string tag, input logic [15:0] exp_pdout,
                             input logic [2:0] exp_fill, input logic exp_full);
    check_output({tag, ".pdout"},   32'(bus.pdout),   32'(exp_pdout));
    check_output({tag, ".sout_hi"}, 32'(bus.sout_hi), 32'(exp_pdout[15:12]));
    check_output({tag, ".sout_lo"}, 32'(bus.sout_lo), 32'(exp_pdout[3:0]));
    check_output({tag, ".fill"},    32'(bus.fill),    32'(exp_fill));
    check_output({tag, ".full"},    32'(bus.full),    32'(exp_full));
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    compared   = 0;
    mismatched = 0;
`ifdef SHIFTREG_ROTATE_EN
    bus.rot = 1'b0;
`endif
    $display("[TB] start");

    // Reset with loads requested: reset must win.
    apply_stimulus(1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 16'hFFFF);
    check_state("reset", 16'h0000, 3'd0, 1'b0);

    // Shift up 1,2,3,4: sin_lo reaches sout_hi only after the 4th edge.
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0, 16'h0000);
    check_state("up1", 16'h0001, 3'd1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h2, 4'h0, 16'h0000);
    check_state("up2", 16'h0012, 3'd2, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h3, 4'h0, 16'h0000);
    check_state("up3", 16'h0123, 3'd3, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h4, 4'h0, 16'h0000);
    check_state("up4", 16'h1234, 3'd4, 1'b1);

    // Load 0x1234, then en=0 with shift-up requested for three cycles.
    apply_stimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 16'h1234);
    check_state("load1234", 16'h1234, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b01, 4'h9, 4'h9, 16'hFFFF);
    end
    check_state("en_off", 16'h1234, 3'd4, 1'b1);

    // Hold mode with enable.
    apply_stimulus(1'b1, 1'b1, 2'b00, 4'h9, 4'h9, 16'hFFFF);
    check_state("hold", 16'h1234, 3'd4, 1'b1);

    // Load 0xA5C3 (fill already full) then shift down with sin_hi=F.
    apply_stimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 16'hA5C3);
    check_state("loadA5C3", 16'hA5C3, 3'd4, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'hF, 16'h0000);
    check_state("down1", 16'hFA5C, 3'd4, 1'b1);

    // Plain reset, then two shifts up.
    apply_stimulus(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
    check_state("reset2", 16'h0000, 3'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h5, 4'h0, 16'h0000);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h6, 4'h0, 16'h0000);
    check_state("up56", 16'h0056, 3'd2, 1'b0);

    // Reset mid-stream while a full load is requested.
    apply_stimulus(1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 16'hFFFF);
    check_state("reset_mid", 16'h0000, 3'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h7, 4'h0, 16'h0000);
    check_state("post_reset_up", 16'h0007, 3'd1, 1'b0);

    // Direction change: a down shift still just adds one to fill.
    apply_stimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h8, 16'h0000);
    check_state("dir_change", 16'h8000, 3'd2, 1'b0);

    // Parallel load from a partial fill jumps straight to DEPTH.
    apply_stimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 16'h0F0F);
    check_state("load_partial", 16'h0F0F, 3'd4, 1'b1);

    // Six shifts up from reset: fill saturates, last four values remain.
    apply_stimulus(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 2'b01, 4'(i), 4'h0, 16'h0000);
    end
    check_state("up5", 16'h2345, 3'd4, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h6, 4'h0, 16'h0000);
    check_state("up6", 16'h3456, 3'd4, 1'b1);

`ifdef SHIFTREG_ROTATE_EN
    // Rotation: serial inputs ignored, fill untouched.
    apply_stimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 16'h1234);
    bus.rot = 1'b1;
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'hE, 4'hE, 16'h0000);
    check_state("rot_up", 16'h2341, 3'd4, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'b10, 4'hE, 4'hE, 16'h0000);
    check_state("rot_down", 16'h1234, 3'd4, 1'b1);
    bus.rot = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 16'h0000);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0, 16'h0000);
    bus.rot = 1'b1;
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'hE, 4'hE, 16'h0000);
    check_state("rot_partial", 16'h0010, 3'd1, 1'b0);
    bus.rot = 1'b0;
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'h2, 4'h0, 16'h0000);
    check_state("rot_off", 16'h0102, 3'd2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shiftreg_univ.md
SHIFTREG_UNIV -- requirements
Module: shiftreg_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, bits per stage (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of stages (>=2).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port en, input, 1, clock enable; 0 freezes all state.
REQ-006 The block SHALL have port mode, input, 2, operation: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
REQ-007 The block SHALL have port sin_lo, input, WIDTH, serial data entering stage 0 on shift up.
REQ-008 The block SHALL have port sin_hi, input, WIDTH, serial data entering stage DEPTH-1 on shift down.
REQ-009 The block SHALL have port pdin, input, WIDTH*DEPTH, load data; stage k = pdin[k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port pdout, output, WIDTH*DEPTH, all stages, same packing as pdin.
REQ-011 The block SHALL have port sout_hi, output, WIDTH, stage DEPTH-1 (shift-up serial out).
REQ-012 The block SHALL have port sout_lo, output, WIDTH, stage 0 (shift-down serial out).
REQ-013 The block SHALL have port fill, output, $clog2(DEPTH+1), count of stages holding written data.
REQ-014 The block SHALL have port full, output, 1, high when fill == DEPTH.

Function
REQ-015 All outputs SHALL be registered or direct functions of registered state; no combinational path from inputs to outputs.
REQ-016 With en=0, stages and fill SHALL hold regardless of mode.
REQ-017 Mode 00 with en=1 SHALL hold stages and fill.
REQ-018 Mode 01 with en=1 SHALL set stage k <= stage k-1 (k>=1), stage 0 <= sin_lo; old stage DEPTH-1 discarded.
REQ-019 Mode 10 with en=1 SHALL set stage k <= stage k+1 (k<=DEPTH-2), stage DEPTH-1 <= sin_hi; old stage 0 discarded.
REQ-020 Mode 11 with en=1 SHALL load all stages from pdin in one cycle.
REQ-021 Latency: sin_lo SHALL appear on sout_hi after exactly DEPTH consecutive shift-up cycles; sin_hi on sout_lo after DEPTH shift-down cycles.
REQ-022 fill SHALL increment by 1 on each enabled shift (either direction), saturating at DEPTH.
REQ-023 fill SHALL become DEPTH on parallel load, including when already DEPTH.
REQ-024 A direction change mid-stream SHALL not alter fill except per REQ-022.
REQ-025 full SHALL assert the same cycle fill reaches DEPTH and remain until reset.

Reset
REQ-026 With rst=0 at a rising edge, all stages SHALL clear to 0, fill to 0, full to 0, overriding en and mode.
REQ-027 Reset asserted mid-shift SHALL discard in-flight data; the first post-reset shift SHALL produce fill=1.
REQ-028 Outputs SHALL be pdout=0, sout_hi=0, sout_lo=0, fill=0, full=0 in the cycle after reset.

Configuration
REQ-029 Macro SHIFTREG_ROTATE_EN, when defined, SHALL add input port rot (1 bit) selecting circular shifting.
REQ-030 With SHIFTREG_ROTATE_EN and rot=1: mode 01 SHALL feed old stage DEPTH-1 into stage 0; mode 10 SHALL feed old stage 0 into stage DEPTH-1; sin_lo/sin_hi ignored; fill unchanged.
REQ-031 With SHIFTREG_ROTATE_EN and rot=0, or without the macro (rot absent), behaviour SHALL be exactly REQ-018..REQ-022.

Verification (WIDTH=4, DEPTH=4)
REQ-032 Reset, then mode 01 with sin_lo=1,2,3,4 on four cycles -> sout_hi=1 after 4th edge, pdout=0x1234, fill=4, full=1.
REQ-033 Load pdin=0xA5C3 (mode 11), then mode 10 with sin_hi=0xF once -> pdout=0xFA5C, sout_lo=0xC, fill=4.
REQ-034 After loading 0x1234, hold en=0 with mode 01 for 3 cycles -> pdout stays 0x1234.
REQ-035 Shift up twice, assert rst=0 with mode 11 and pdin=0xFFFF -> pdout=0, fill=0, full=0; next shift -> fill=1.
REQ-036 SHIFTREG_ROTATE_EN defined: load 0x1234, rot=1, mode 01 one cycle -> pdout=0x2341, fill=4; mode 10 one cycle -> 0x1234.
REQ-037 Shift up 6 times from reset -> fill saturates at 4, only last four sin_lo values in pdout.
